// File: rtl/iurt_pkg.sv
// iurt_pkg: shared types and constants for the upstream byte arbiter.
package iurt_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_DATA} state_t;
   localparam logic [4:0] HDR_PREFIX = 5'b11111;
   function automatic int burst_cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction
endpackage

// File: rtl/iurt_up_arbiter_if.sv
// iurt_up_arbiter_if: requester and upstream handshake bundle of the arbiter.
interface iurt_up_arbiter_if #(parameter int N = 4);
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           data_up_ready;
   logic           data_up_valid;
   logic [7:0]     data_up;
   logic [N-1:0]   grant;
   modport master (
      input  req_valid, req_data, data_up_ready,
      output req_ready, data_up_valid, data_up, grant
   );
   modport slave (
      output req_valid, req_data, data_up_ready,
      input  req_ready, data_up_valid, data_up, grant
   );
endinterface

// File: rtl/iurt_rr_pick.sv
// iurt_rr_pick: combinational round-robin picker, scans last+1, last+2, ... modulo N.
module iurt_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  win,
   output logic [IW-1:0] win_idx
);
   logic [IW-1:0] j;
   // Scanning from the farthest offset down lets the nearest requester overwrite.
   always_comb begin
      win = '0;
      win_idx = '0;
      j = '0;
      for (int k = N; k >= 1; k--) begin
         j = IW'((int'(last) + k) % N);
         if (req[j]) begin
            win = '0;
            win[j] = 1'b1;
            win_idx = j;
         end
      end
   end
endmodule

// File: rtl/iurt_up_arbiter.sv
// iurt_up_arbiter: shares one registered upstream byte channel among N requesters,
// with round-robin bursts, optional channel header bytes and a one-cycle gap between pulses.
module iurt_up_arbiter
   import iurt_pkg::*;
#(
   parameter int N         = 4,
   parameter int MAX_BURST = 16,
   parameter int HEADER_EN = 1
) (
   input logic             clk,
   input logic             rst_n,
   input logic             ce,
   iurt_up_arbiter_if.master bus
);
   localparam int IW = $clog2(N);
   localparam int BW = burst_cnt_w(MAX_BURST);
   state_t        state;
   logic [N-1:0]  grant_q, pick;
   logic [IW-1:0] cur, last_grant, last_sent, pick_idx;
   logic          sent_vld;
   logic [BW-1:0] burst;
   logic [7:0]    hold, up_data, sel_data;
   logic          hold_full, gap, up_valid;
   logic          sel_valid, room, send;
   iurt_rr_pick #(.N(N), .IW(IW)) u_pick (
      .req     (bus.req_valid),
      .last    (last_grant),
      .win     (pick),
      .win_idx (pick_idx)
   );
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) sel_data = grant_q[i] ? bus.req_data[8*i +: 8] : sel_data;
   end
   assign sel_valid         = |(bus.req_valid & grant_q);
   assign room              = (state == ST_DATA) & ~hold_full & (burst < BW'(MAX_BURST));
   assign send              = bus.data_up_ready & hold_full & ~gap;
   assign bus.req_ready     = room ? grant_q : '0;
   assign bus.grant         = grant_q;
   assign bus.data_up_valid = up_valid;
   assign bus.data_up       = up_data;
   // Accept and release are mutually exclusive, and neither can coincide with a send
   // because both require an empty holding register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         grant_q    <= '0;
         cur        <= '0;
         last_grant <= IW'(N - 1);
         last_sent  <= '0;
         sent_vld   <= 1'b0;
         burst      <= '0;
         hold       <= '0;
         hold_full  <= 1'b0;
         gap        <= 1'b0;
         up_valid   <= 1'b0;
         up_data    <= '0;
      end else if (!ce) begin
         up_valid <= 1'b0;
      end else begin
         up_valid <= send;
         gap      <= send;
         if (send) begin
            up_data   <= hold;
            hold_full <= 1'b0;
         end
         case (state)
            ST_IDLE: if (|bus.req_valid) begin
               grant_q <= pick;
               cur     <= pick_idx;
               burst   <= '0;
               if (HEADER_EN != 0 && (!sent_vld || pick_idx != last_sent)) begin
                  hold      <= {HDR_PREFIX, 3'(pick_idx)};
                  hold_full <= 1'b1;
                  state     <= ST_HEADER;
               end else begin
                  state <= ST_DATA;
               end
            end
            ST_HEADER: if (send) begin
               state     <= ST_DATA;
               last_sent <= cur;
               sent_vld  <= 1'b1;
            end
            ST_DATA: if (sel_valid && room) begin
               hold      <= sel_data;
               hold_full <= 1'b1;
               burst     <= burst + 1'b1;
            end else if (!hold_full && (!sel_valid || burst == BW'(MAX_BURST))) begin
               last_grant <= cur;
               grant_q    <= '0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
